// File: rtl/mic3_sample_sched.sv
// mic3_sample_sched: periodic CS_N/SCLK sequencer and 12-bit sample capture for a PmodMIC3 ADC
//   sysclk/sysrst            : system clock, async active-high reset
//   enable                   : level run request; a started frame always completes
//   spi_cs_n/spi_sclk        : ADC chip select (active low) and serial clock (idles high)
//   spi_sdata                : ADC serial data, asynchronous, synchronised internally
//   sample_data/valid/ready  : valid/ready sample handoff, newest sample wins
//   overrun                  : pulse when an unconsumed sample is overwritten
//   frame_err                : pulse with a sample load whose leading 4 bits are not zero
//   busy                     : high whenever the sequencer is outside ST_IDLE
module mic3_sample_sched #(
  parameter int CLK_DIVIDE    = 16,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int CSN_SETUP     = 3
) (
  input  logic        sysclk,
  input  logic        sysrst,
  input  logic        enable,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  input  logic        spi_sdata,
  output logic [11:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_QUIET} state_t;
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CSN_SETUP - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIVIDE / 2 - 1);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, sr_q, sr_d;
  logic [PW-1:0] per_q, per_d;
  logic [4:0] bits_q, bits_d;
  logic [1:0] sync_q;
  logic [11:0] data_q, data_d;
  logic dummy_q, dummy_d, cs_q, cs_d, sclk_q, sclk_d;
  logic valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d, busy_q, busy_d;
  logic setup_done, tick, rise, frame_end, period_end, start, load;
  assign setup_done = state_q == ST_SETUP && cnt_q == SETUP_LAST;
  assign tick       = state_q == ST_SHIFT && cnt_q == HALF_LAST;
  assign rise       = tick && !sclk_q;
  // the half-period after the 16th rising edge closes the frame instead of dropping sclk
  assign frame_end  = tick && sclk_q && bits_q == 5'd16;
  assign period_end = state_q == ST_QUIET && per_q == PER_LAST;
  assign load       = frame_end && !dummy_q;
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
      sync_q  <= '0;
      data_q  <= '0;
      dummy_q <= 1'b1;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      bits_q  <= bits_d;
      sr_q    <= sr_d;
      sync_q  <= {sync_q[0], spi_sdata};
      data_q  <= data_d;
      dummy_q <= dummy_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = enable ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_d = setup_done ? ST_SHIFT : ST_SETUP;
      ST_SHIFT: state_d = frame_end ? ST_QUIET : ST_SHIFT;
      default:  state_d = period_end ? (enable ? ST_SETUP : ST_IDLE) : ST_QUIET;
    endcase
  end
  // start marks the edge on which cs_n falls, which also anchors the sample period
  assign start = state_d == ST_SETUP && state_q != ST_SETUP;
  always_comb begin
    cs_d    = state_d == ST_IDLE || state_d == ST_QUIET;
    sclk_d  = state_d != ST_SHIFT ? 1'b1 : state_q == ST_SETUP ? 1'b0 : tick ? ~sclk_q : sclk_q;
    cnt_d   = (start || setup_done || tick) ? 16'd0 : cnt_q + 16'd1;
    per_d   = start ? '0 : per_q + PW'(1);
    bits_d  = start ? 5'd0 : bits_q + {4'd0, rise};
    sr_d    = rise ? {sr_q[14:0], sync_q[1]} : sr_q;
    dummy_d = (state_q == ST_IDLE && enable) ? 1'b1 : frame_end ? 1'b0 : dummy_q;
    data_d  = load ? sr_q[11:0] : data_q;
    valid_d = load || (valid_q && !sample_ready);
    ovr_d   = load && valid_q && !sample_ready;
    ferr_d  = load && |sr_q[15:12];
    busy_d  = state_d != ST_IDLE;
  end
  assign spi_cs_n     = cs_q;
  assign spi_sclk     = sclk_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign frame_err    = ferr_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_mic3_sample_sched.sv
// tb_mic3_sample_sched: directed frame-by-frame check of mic3_sample_sched with an ADC shift model
module tb_mic3_sample_sched;
  logic sysclk = 1'b0, sysrst = 1'b1, enable = 1'b0, spi_sdata = 1'b0, sample_ready = 1'b0;
  logic spi_cs_n, spi_sclk, sample_valid, overrun, frame_err, busy;
  logic [11:0] sample_data;
  logic [15:0] adc_word = 16'h0, cur = 16'h0;
  int idx = 0, n_chk = 0, n_fail = 0;
  int cyc = 0, last_fall = 0, low_cnt = 0, falls = 0, sclk_bad = 0;
  bit have_fall = 0, chk_period = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1;

  mic3_sample_sched #(.CLK_DIVIDE(16), .SAMPLE_PERIOD(400), .CSN_SETUP(3)) dut (
    .sysclk(sysclk), .sysrst(sysrst), .enable(enable), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_sdata(spi_sdata), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .frame_err(frame_err), .busy(busy));

  always #5 sysclk = ~sysclk;

  always @(negedge spi_cs_n) begin
    cur = adc_word;
    idx = 0;
  end
  always @(negedge spi_sclk) if (spi_cs_n === 1'b0 && idx < 16) begin
    spi_sdata = cur[15 - idx];
    idx++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cs(input logic lvl, input string nm);
    bit ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(posedge sysclk);
      #1;
      ok = (spi_cs_n === lvl);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  always @(negedge sysclk) begin
    cyc++;
    if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
      if (chk_period && have_fall) chk("cs_n fall period", 32'(cyc - last_fall), 32'd400);
      last_fall = cyc;
      have_fall = 1;
      low_cnt = 0;
      falls = 0;
    end
    if (spi_cs_n === 1'b0) low_cnt++;
    if (prev_sclk === 1'b1 && spi_sclk === 1'b0) falls++;
    if (prev_cs === 1'b0 && spi_cs_n === 1'b1 && !sysrst) begin
      chk("cs_n low cycles", 32'(low_cnt), 32'd259);
      chk("sclk falls per frame", 32'(falls), 32'd16);
    end
    if (spi_cs_n === 1'b1 && spi_sclk === 1'b0) sclk_bad++;
    prev_cs = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  typedef struct {
    logic [15:0] word;
    logic        rdy_end;
    logic        exp_v;
    logic [11:0] exp_d;
    logic        exp_o;
    logic        exp_f;
    logic        rdy_after;
    logic        exp_v2;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h0ABC, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0123, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h0111, 1'b0, 1'b1, 12'h111, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'h0222, 1'b0, 1'b1, 12'h222, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{16'h0333, 1'b1, 1'b1, 12'h333, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h8FFF, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{16'hF555, 1'b0, 1'b1, 12'h555, 1'b1, 1'b1, 1'b1, 1'b0};
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset cs_n", 32'(spi_cs_n), 32'd1);
    chk("reset sclk", 32'(spi_sclk), 32'd1);
    chk("reset data", 32'(sample_data), 32'd0);
    chk("reset valid", 32'(sample_valid), 32'd0);
    chk("reset pulses", 32'({overrun, frame_err}), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    sysrst = 1'b0;
    @(posedge sysclk);
    #1;
    chk("idle cs_n", 32'(spi_cs_n), 32'd1);
    enable = 1'b1;
    chk_period = 1;
    for (int i = 0; i < 8; i++) begin
      adc_word = tbl[i].word;
      wait_cs(1'b0, "frame start");
      repeat (258) @(posedge sysclk);
      #1 sample_ready = tbl[i].rdy_end;
      wait_cs(1'b1, "frame end");
      chk($sformatf("row%0d valid", i), 32'(sample_valid), 32'(tbl[i].exp_v));
      chk($sformatf("row%0d data", i), 32'(sample_data), 32'(tbl[i].exp_d));
      chk($sformatf("row%0d overrun", i), 32'(overrun), 32'(tbl[i].exp_o));
      chk($sformatf("row%0d frame_err", i), 32'(frame_err), 32'(tbl[i].exp_f));
      sample_ready = tbl[i].rdy_after;
      repeat (2) @(posedge sysclk);
      #1;
      chk($sformatf("row%0d valid later", i), 32'(sample_valid), 32'(tbl[i].exp_v2));
      chk($sformatf("row%0d pulses end", i), 32'({overrun, frame_err}), 32'd0);
    end
    chk_period = 0;
    adc_word = 16'h0456;
    sample_ready = 1'b0;
    wait_cs(1'b0, "drop frame start");
    repeat (50) @(posedge sysclk);
    #1 enable = 1'b0;
    wait_cs(1'b1, "drop frame end");
    chk("drop valid", 32'(sample_valid), 32'd1);
    chk("drop data", 32'(sample_data), 32'h456);
    chk("drop busy in quiet", 32'(busy), 32'd1);
    repeat (140) @(posedge sysclk);
    #1 chk("busy at quiet end", 32'(busy), 32'd1);
    @(posedge sysclk);
    #1 chk("busy after idle", 32'(busy), 32'd0);
    repeat (20) @(posedge sysclk);
    #1 chk("idle stays cs high", 32'(spi_cs_n), 32'd1);
    enable = 1'b1;
    adc_word = 16'h0777;
    wait_cs(1'b0, "reset frame start");
    repeat (100) @(posedge sysclk);
    #1 sysrst = 1'b1;
    #1;
    chk("rst cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst sclk", 32'(spi_sclk), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(sample_valid), 32'd0);
    chk("rst data", 32'(sample_data), 32'd0);
    repeat (3) @(posedge sysclk);
    #1 sysrst = 1'b0;
    adc_word = 16'h0999;
    sample_ready = 1'b1;
    wait_cs(1'b0, "dummy start");
    wait_cs(1'b1, "dummy end");
    chk("post-rst dummy valid", 32'(sample_valid), 32'd0);
    chk("post-rst dummy data", 32'(sample_data), 32'd0);
    adc_word = 16'h0ABC;
    wait_cs(1'b0, "real start");
    wait_cs(1'b1, "real end");
    chk("post-rst valid", 32'(sample_valid), 32'd1);
    chk("post-rst data", 32'(sample_data), 32'hABC);
    enable = 1'b0;
    repeat (200) @(posedge sysclk);
    #1 chk("sclk high while cs_n high", 32'(sclk_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mic3_sample_sched.md
# mic3_sample_sched

Periodic sample scheduler and SPI frame sequencer for the PmodMIC3 (ADCS7476-class 12-bit ADC) on a Pmod header. It drives CS_N and SCLK at a fixed sample cadence and discards the mandatory power-up frame. It captures each 16-bit frame into a 12-bit sample and hands samples to the downstream audio path over a valid/ready interface, with an overrun indication. It sits between the header IOBUFs and the sample consumer (FIFO/ILA/filter).

## Interface

Parameters:
- CLK_DIVIDE, 16: sysclk cycles per SCLK period; even, >= 16 (SCLK <= 6.25 MHz at 100 MHz sysclk).
- SAMPLE_PERIOD, 2500: sysclk cycles between successive CS_N falling edges (40 kHz); must be >= CSN_SETUP + 16*CLK_DIVIDE + 4.
- CSN_SETUP, 3: sysclk cycles from CS_N falling to first SCLK falling edge.

Ports:
- sysclk  in  1  100 MHz system clock; the only clock.
- sysrst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- spi_cs_n  out  1  ADC chip select, active low.
- spi_sclk  out  1  ADC serial clock, idles high.
- spi_sdata  in  1  ADC serial data, asynchronous; double-flop synchronised internally.
- sample_data  out  12  last captured sample, unsigned.
- sample_valid  out  1  sample_data holds an unconsumed sample.
- sample_ready  in  1  consumer accepts sample when high with sample_valid.
- overrun  out  1  1-cycle pulse: an unconsumed sample was overwritten.
- frame_err  out  1  1-cycle pulse with sample load: leading 4 bits not zero.
- busy  out  1  high from leaving ST_IDLE until return to ST_IDLE.

## Operation

- States: ST_IDLE, ST_SETUP, ST_SHIFT, ST_QUIET.
- ST_IDLE: cs_n=1, sclk=1. When enable=1, the next edge drives cs_n=0, arms the dummy flag, zeroes the period counter, and enters ST_SETUP.
- ST_SETUP: sclk held high for CSN_SETUP cycles, then sclk falls; enter ST_SHIFT.
- ST_SHIFT: sclk toggles every CLK_DIVIDE/2 cycles. The edge that sets sclk 0->1 shifts the synchronised sdata into a 16-bit shift register, MSB first. After the 16th rising edge, the next edge drives cs_n=1 (sclk stays high) and enters ST_QUIET.
- Frame result at the cs_n rising edge:
  - If the dummy flag is set: discard the result and clear the flag.
  - Otherwise: sample_data <= bits[11:0]; frame_err pulses if bits[15:12] != 0.
- ST_QUIET: cs_n=1, sclk=1 until the period counter reaches SAMPLE_PERIOD-1.
  - If enable=1: cs_n=0 and re-enter ST_SETUP (no dummy).
  - Otherwise: enter ST_IDLE.
- Enable deassertion never truncates a frame. A frame in progress completes and delivers its sample. The dummy frame is repeated on every exit from ST_IDLE.
- Handshake:
  - Transfer occurs on any edge with sample_valid && sample_ready.
  - sample_valid clears after transfer unless a new sample loads on the same edge. In that case valid stays 1, the new data appears, and overrun does not pulse.
  - A new sample loading while valid=1 and ready=0 overwrites the old sample (newest wins), keeps valid=1, and pulses overrun.
  - sample_data is stable while valid=1 and no load occurs.

## Timing

- Reset values (applied asynchronously): spi_cs_n=1, spi_sclk=1, sample_data=0, sample_valid=0, overrun=0, frame_err=0, busy=0, state ST_IDLE, dummy flag set, counters 0.
- Reset mid-frame aborts the frame immediately with no sample and no pulses. After release, the dummy frame is run again.
- cs_n low for exactly CSN_SETUP + 16*CLK_DIVIDE cycles per frame; 16 SCLK falling edges and 16 rising edges per frame.
- cs_n falling edges are exactly SAMPLE_PERIOD cycles apart while enable=1.
- Latency: sample_valid, sample_data, frame_err and overrun update on the same edge that cs_n rises.
- sdata capture uses the 2-flop synchronised value. The bit launched on SCLK falling is sampled CLK_DIVIDE/2 cycles later, which is >= 8 cycles of margin.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

Bench parameters: CLK_DIVIDE=16, SAMPLE_PERIOD=400, CSN_SETUP=3. The ADC model shifts a programmable 16-bit word out on SCLK falling edges.

- Enable after reset; model word 0x0ABC, then 0x0123 -> no valid for the first frame; second frame gives sample_data=0x123 and sample_valid=1 at cs_n rise.
- Cadence: enable held for 4 frames -> cs_n falls every 400 cycles, low 259 cycles each, 16 SCLK falls per frame, SCLK high whenever cs_n=1.
- Backpressure: ready=0 across two non-dummy frames (0x0111, 0x0222) -> one overrun pulse at the second load, sample_data=0x222; ready=1 then clears valid.
- Simultaneous ready and load: ready=1 on the cs_n rise edge with valid=1 -> valid stays 1, new data appears, no overrun.
- Error frame: word 0x8FFF -> sample_data=0xFFF, frame_err pulses 1 cycle.
- Enable dropped mid-frame -> frame completes, sample delivered, ST_IDLE after quiet. sysrst asserted mid-frame -> cs_n=1, sclk=1 immediately; the next enable yields a dummy frame first.
